// File: rtl/matmul_pkg.sv
// Shared types for the matmul MAC sequencer: FSM state encoding, index widths
// and the default tag layout that travels alongside each product.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    DRAIN     = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_t;

  // A dimension of 1 still needs a 1-bit index port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_M   = 4;
  localparam int unsigned DEF_K   = 4;
  localparam int unsigned DEF_N   = 4;
  localparam int unsigned DEF_I_W = idx_w(DEF_M);
  localparam int unsigned DEF_J_W = idx_w(DEF_N);
  localparam int unsigned DEF_K_W = idx_w(DEF_K);

  typedef struct packed {
    logic               valid;
    logic [DEF_I_W-1:0] i;
    logic [DEF_J_W-1:0] j;
    logic [DEF_K_W-1:0] k;
  } tag_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// Fixed-latency shift register carrying {valid, i, j, k} tags so that index
// information lines up with the product leaving the memory/multiplier chain.
module mac_tag_pipe
  import matmul_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter type         tag_type   = tag_t
) (
  input  logic    clk,
  input  logic    resetn,
  input  tag_type tag_in,
  output tag_type tag_out
);

  tag_type stage [PIPE_DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
        stage[s] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int unsigned s = 1; s < PIPE_DEPTH; s++) begin
        stage[s] <= stage[s-1];
      end
    end
  end

  assign tag_out = stage[PIPE_DEPTH-1];

endmodule

// File: rtl/matmul_mac_sequencer.sv
// Walks the (i, j, k) space of an MxK by KxN product, issues A/B reads and
// delays each index tuple so it arrives with its product at the accumulator.
module matmul_mac_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned M          = 4,
  parameter int unsigned K          = 4,
  parameter int unsigned N          = 4,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  mac_done,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [idx_w(M)-1:0]   row_addr_a,
  output logic [idx_w(K)-1:0]   col_addr_a,
  output logic [idx_w(K)-1:0]   row_addr_b,
  output logic [idx_w(N)-1:0]   col_addr_b,
  output logic                  mult_done_reg,
  output logic [idx_w(M)-1:0]   matrix_a_row_addr_counter_reg,
  output logic [idx_w(K)-1:0]   matrix_a_col_addr_counter_reg,
  output logic [idx_w(K)-1:0]   matrix_b_row_addr_counter_reg,
  output logic [idx_w(N)-1:0]   matrix_b_col_addr_counter_reg
);

  localparam int unsigned IW = idx_w(M);
  localparam int unsigned JW = idx_w(N);
  localparam int unsigned KW = idx_w(K);
  localparam int unsigned DW = $clog2(PIPE_DEPTH + 1);

  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
  } seq_tag_t;

  seq_state_t    state;
  logic [IW-1:0] i_cnt;
  logic [JW-1:0] j_cnt;
  logic [KW-1:0] k_cnt;
  logic [DW-1:0] drain_cnt;
  logic          mac_seen;
  seq_tag_t      tag_in;
  seq_tag_t      tag_out;

  always_comb begin
    busy   = (state != IDLE);
    rd_en  = (state == ISSUE) && !stall;
    // Bubbles still carry the held counters so the outputs stay stable.
    tag_in = '{valid: rd_en, i: i_cnt, j: j_cnt, k: k_cnt};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
      mac_seen  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && mac_done) mac_seen <= 1'b1;
      case (state)
        IDLE: begin
          i_cnt    <= '0;
          j_cnt    <= '0;
          k_cnt    <= '0;
          mac_seen <= 1'b0;
          if (start) state <= ISSUE;
        end
        ISSUE: begin
          if (rd_en) begin
            if (k_cnt == K_LAST) begin
              k_cnt <= '0;
              if (j_cnt == J_LAST) begin
                j_cnt <= '0;
                if (i_cnt == I_LAST) begin
                  i_cnt     <= '0;
                  drain_cnt <= DW'(PIPE_DEPTH);
                  state     <= DRAIN;
                end else begin
                  i_cnt <= i_cnt + 1'b1;
                end
              end else begin
                j_cnt <= j_cnt + 1'b1;
              end
            end else begin
              k_cnt <= k_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= WAIT_DONE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        WAIT_DONE: begin
          if (mac_seen || mac_done) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mac_tag_pipe #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .tag_type   (seq_tag_t)
  ) u_tag_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign row_addr_a                    = i_cnt;
  assign col_addr_a                    = k_cnt;
  assign row_addr_b                    = k_cnt;
  assign col_addr_b                    = j_cnt;
  assign mult_done_reg                 = tag_out.valid;
  assign matrix_a_row_addr_counter_reg = tag_out.i;
  assign matrix_a_col_addr_counter_reg = tag_out.k;
  assign matrix_b_row_addr_counter_reg = tag_out.k;
  assign matrix_b_col_addr_counter_reg = tag_out.j;

endmodule
